icache_assoc: RTL and testbench

- Parametrised successor to the current single-way instruction cache.
- Set-associative (1 or 2 ways) read-only instruction cache. Line size, set count and way count are configurable.
- Line refills use an AXI4 INCR read burst. Cache-wide invalidate via a flush counter. mem_start base-offset relocation.
- Sits between the fetch stage and the AXI instruction port. Hits complete combinationally in the request cycle.

---
 rtl/icache_assoc.sv | 243 ++++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: 1- or 2-way set-associative read-only instruction cache.
//
// Lookups use asynchronous-read tag/data arrays, so a hit completes in the
// request cycle. A miss latches the physical line address and refills the
// whole line with a single AXI4 INCR read burst, then writes it into the
// victim way. A flush invalidates every set, one set per cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mem_start_valid/_input  load the relocation base (any state)
//   req_valid, inst_addr    fetch request; address relative to the base
//   ready, inst_rdata       hit handshake / hit word (0x3F when no hit)
//   flush                   one-cycle pulse: invalidate all lines
//   busy                    controller not idle
//   error                   00 none, 01 AXI error, 10 rlast protocol error
//   m_ar*, m_r*             AXI4 read address / read data channels
//
// Parameters: WAYS (1 or 2), SETS (power of two, >= 2),
//             LINE_WORDS (power of two, 2..16), ADDR_W.
module icache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 512,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_start_valid,
  input  logic [ADDR_W-1:0] mem_start_input,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              ready,
  output logic [31:0]       inst_rdata,
  input  logic              flush,
  output logic              busy,
  output logic [1:0]        error,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast
);

  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int IDX_W = $clog2(SETS);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int LN_W  = ADDR_W - OFF_W;
  localparam int TAG_W = LN_W - IDX_W;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_AR, S_R, S_FILL, S_ERROR
  } state_t;

  // Controller state
  state_t            state_q;
  logic [IDX_W-1:0]  fcnt_q;      // flush sweep pointer
  logic [WRD_W-1:0]  bcnt_q;      // refill beat pointer
  logic [LN_W-1:0]   line_q;      // latched physical line address of the miss
  logic              victim_q;    // way chosen for the refill
  logic              arvalid_q;
  logic              busy_q;
  logic              pend_q;      // flush seen while a refill was in flight
  logic              bad_q;       // current refill is unusable
  logic [1:0]        error_q;
  logic [ADDR_W-1:0] mem_start_q;

  // Storage; valid/LRU are cleared by the FLUSH sweep, not by rst directly
  logic [WAYS-1:0]   valid_q [SETS];
  logic [SETS-1:0]   lru_q;       // way to evict next when both are valid
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][LINE_WORDS];
  logic [LINE_WORDS-1:0][31:0] lbuf_q;

  // Lookup
  logic [ADDR_W-1:0] paddr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WRD_W-1:0]  woff;
  logic              hit;
  logic              hit_way;
  logic              victim;
  logic              unused_paddr;

  assign paddr        = mem_start_q + inst_addr;
  assign idx          = paddr[OFF_W +: IDX_W];
  assign tag          = paddr[ADDR_W-1 -: TAG_W];
  assign woff         = paddr[2 +: WRD_W];
  assign unused_paddr = ^paddr[1:0];

  // While the sweep runs the valid bits are half-cleared, so every line is
  // treated as invalid until it finishes.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (state_q != S_FLUSH && valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the LRU way
  always_comb begin
    victim = (WAYS > 1) ? lru_q[idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = 1'(w);
    end
  end

  assign ready      = req_valid && hit && (state_q == S_IDLE);
  assign inst_rdata = hit ? data_q[idx][hit_way][woff] : 32'h0000_003F;
  assign busy       = busy_q;
  assign error      = error_q;

  // AXI read channel
  assign m_arvalid = arvalid_q;
  assign m_araddr  = {line_q, {OFF_W{1'b0}}};
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_rready  = 1'b1;

  // Beat classification during R
  logic beat_last, beat_axi, beat_prot;
  assign beat_last = (bcnt_q == WRD_W'(LINE_WORDS - 1));
  assign beat_axi  = (m_rresp != 2'b00);
  // rlast must arrive exactly on the final expected beat
  assign beat_prot = (m_rlast != beat_last);

  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  assign fidx = line_q[IDX_W-1:0];
  assign ftag = line_q[LN_W-1:IDX_W];

  // Controller
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FLUSH;
      fcnt_q      <= '0;
      bcnt_q      <= '0;
      line_q      <= '0;
      victim_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      busy_q      <= 1'b1;
      pend_q      <= 1'b0;
      bad_q       <= 1'b0;
      error_q     <= 2'b00;
      mem_start_q <= '0;
    end else begin
      if (mem_start_valid) mem_start_q <= mem_start_input;
      if (flush && (state_q == S_AR || state_q == S_R || state_q == S_FILL))
        pend_q <= 1'b1;

      unique case (state_q)
        S_FLUSH: begin
          fcnt_q <= fcnt_q + 1'b1;
          if (fcnt_q == IDX_W'(SETS - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          // a flush (new or deferred) wins over a miss in the same cycle
          if (flush || pend_q) begin
            state_q <= S_FLUSH;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (req_valid && !hit) begin
            line_q    <= paddr[ADDR_W-1:OFF_W];
            victim_q  <= victim;
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_AR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_R;
            bcnt_q    <= '0;
            bad_q     <= 1'b0;
          end
        end
        S_R: begin
          if (m_rvalid) begin
            bcnt_q <= bcnt_q + 1'b1;
            // first error wins; it stays until rst
            if (error_q == 2'b00 && beat_axi)       error_q <= 2'b01;
            else if (error_q == 2'b00 && beat_prot) error_q <= 2'b10;
            if (beat_axi || beat_prot) bad_q <= 1'b1;
            if (m_rlast) begin
              if (bad_q || beat_axi || beat_prot) state_q <= S_ERROR;
              else                                state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  // Line buffer collects beats; stray beats outside R are dropped
  always_ff @(posedge clk) begin
    if (state_q == S_R && m_rvalid) lbuf_q[bcnt_q] <= m_rdata;
  end

  // Tag/data write on FILL
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_FILL) begin
      tag_q[fidx][victim_q] <= ftag;
      for (int k = 0; k < LINE_WORDS; k++) data_q[fidx][victim_q][k] <= lbuf_q[k];
    end
  end

  // Valid/LRU: sweep clear, fill install, hit touch
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_FLUSH) begin
        valid_q[fcnt_q] <= '0;
        lru_q[fcnt_q]   <= 1'b0;
      end else if (state_q == S_FILL) begin
        valid_q[fidx][victim_q] <= 1'b1;
        lru_q[fidx]             <= ~victim_q;
      end else if (ready) begin
        lru_q[idx] <= ~hit_way;
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc at default parameters. The reference model keeps,
// per set, a recency-ordered list of resident line addresses; data comes
// from a memory function of the physical address, served by an inline AXI
// slave.
module tb_icache_assoc;

  localparam int WAYS = 2;
  localparam int SETS = 512;
  localparam int LW   = 16;
  localparam int AW   = 32;
  localparam int OFF  = $clog2(LW * 4);
  localparam int IDXB = $clog2(SETS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_start_valid = 1'b0;
  logic [AW-1:0] mem_start_input = '0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          ready;
  logic [31:0]   inst_rdata;
  logic          flush = 1'b0;
  logic          busy;
  logic [1:0]    error;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 1'b0;

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_start_valid(mem_start_valid), .mem_start_input(mem_start_input),
    .req_valid(req_valid), .inst_addr(inst_addr),
    .ready(ready), .inst_rdata(inst_rdata),
    .flush(flush), .busy(busy), .error(error),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mode = 1'b0;         // 0: word = byte offset in line, 1: hashed
  logic [31:0] base_m = '0;
  logic [31:0] m_line [SETS][WAYS]; // index 0 = most recently used
  bit          m_vld  [SETS][WAYS];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return mode ? (a ^ {a[15:0], a[31:16]} ^ 32'h5EED_0000) : (a & 32'h3F);
  endfunction

  function automatic int m_find(input logic [31:0] ln);
    int s = int'(ln % SETS);
    for (int w = 0; w < WAYS; w++)
      if (m_vld[s][w] && m_line[s][w] == ln) return w;
    return -1;
  endfunction

  // Move/insert ln to the MRU slot; entries above 'from' shift down by one
  function automatic void m_promote(input logic [31:0] ln, input int from);
    int s = int'(ln % SETS);
    for (int w = from; w > 0; w--) begin
      m_line[s][w] = m_line[s][w-1];
      m_vld[s][w]  = m_vld[s][w-1];
    end
    m_line[s][0] = ln;
    m_vld[s][0]  = 1'b1;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
  endfunction

  // ---------------- helpers ----------------
  // Called at a negedge(+1) inside the first FLUSH cycle; counts busy cycles
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_start_valid = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    @(negedge clk); #1;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_error", error, 0);
    chk("rst_ready", ready, 0);
    chk("rst_rready", m_rready, 1);
    rst = 1'b0;
    m_clear();
    base_m = '0;
    wait_idle(n);
    chk("rst_flush_len", n, SETS);
  endtask

  task automatic set_base(input logic [31:0] v);
    @(negedge clk); mem_start_valid = 1'b1; mem_start_input = v;
    @(negedge clk); mem_start_valid = 1'b0;
    base_m = v;
  endtask

  task automatic fetch(input logic [31:0] ia, input int err_b, input int last_b,
                       input int flush_b, input int rst_b, input int ar_dly, input int gap);
    logic [31:0] pa, ln, ar;
    int n, pos, perr, exp_err;
    bit did_rst;
    pa  = base_m + ia;
    ln  = pa >> OFF;
    pos = m_find(ln);
    @(negedge clk); req_valid = 1'b1; inst_addr = ia; #1;
    if (pos >= 0) begin
      chk("hit_ready", ready, 1);
      chk("hit_data", inst_rdata, memword(pa));
      chk("hit_no_ar", m_arvalid, 0);
      m_promote(ln, pos);
      @(negedge clk); req_valid = 1'b0;
      return;
    end
    chk("miss_ready", ready, 0);
    chk("miss_data", inst_rdata, 32'h3F);
    n = 0;
    while (!m_arvalid && n < 8) begin @(negedge clk); #1; n++; end
    chk("ar_wait", n, 1);
    chk("ar_valid", m_arvalid, 1);
    chk("ar_addr", m_araddr, ln << OFF);
    chk("ar_len", m_arlen, LW - 1);
    chk("ar_size", m_arsize, 2);
    chk("ar_burst", m_arburst, 1);
    ar = m_araddr;
    repeat (ar_dly) begin @(negedge clk); #1; chk("ar_hold", m_arvalid, 1); end
    m_arready = 1'b1;
    @(negedge clk); m_arready = 1'b0;
    did_rst = 1'b0;
    for (int b = 0; b <= last_b; b++) begin
      if (gap > 0 && b % 4 == 2) begin m_rvalid = 1'b0; repeat (gap) @(negedge clk); end
      m_rvalid = 1'b1;
      m_rdata  = memword(ar + 32'(4 * b));
      m_rresp  = (b == err_b) ? 2'b10 : 2'b00;
      m_rlast  = (b == last_b);
      flush    = (b == flush_b);
      rst      = (b == rst_b);
      @(negedge clk);
      flush = 1'b0;
      if (rst) begin
        rst = 1'b0; did_rst = 1'b1; #1;
        chk("rstR_arvalid", m_arvalid, 0);
        chk("rstR_busy", busy, 1);
        chk("rstR_error", error, 0);
        chk("rstR_ready", ready, 0);
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    if (did_rst) begin
      req_valid = 1'b0; m_clear(); base_m = '0; #1;
      wait_idle(n);
      chk("rstR_flush_done", busy, 0);
      return;
    end
    perr = (last_b < LW - 1) ? last_b : ((last_b > LW - 1) ? LW - 1 : -1);
    if (err_b >= 0 && err_b <= last_b && (perr < 0 || err_b <= perr)) exp_err = 1;
    else if (perr >= 0) exp_err = 2;
    else exp_err = 0;
    #1;
    if (exp_err != 0) begin
      chk("err_code", error, exp_err);
      chk("err_busy", busy, 1);
      repeat (3) begin
        @(negedge clk); #1;
        chk("err_ready", ready, 0);
        chk("err_sticky", error, exp_err);
      end
      req_valid = 1'b0;
      return;
    end
    n = 0;
    while (!ready && n < 6) begin @(negedge clk); #1; n++; end
    chk("fill_lat", n, 1);
    chk("fill_ready", ready, 1);
    chk("fill_data", inst_rdata, memword(pa));
    chk("fill_error", error, 0);
    m_promote(ln, WAYS - 1);
    @(negedge clk); req_valid = 1'b0; #1;
    if (flush_b >= 0) begin
      m_clear();
      wait_idle(n);
      chk("pend_flush_len", n, SETS);
    end
  endtask

  task automatic fetch_ok(input logic [31:0] ia);
    fetch(ia, -1, LW - 1, -1, -1, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] pa;
    mode = 1'b0;
    do_reset();

    // cold miss with relocation, then a same-line hit
    set_base(32'h1000);
    fetch_ok(32'h44);
    fetch_ok(32'h78);

    // two-way replacement: A, B same set; touch A; C evicts B
    set_base(32'h0);
    fetch_ok(32'h0000);
    fetch_ok(32'h8000);
    fetch_ok(32'h0000);
    fetch_ok(32'h1_0000);
    fetch_ok(32'h0000);
    fetch_ok(32'h8000);

    // flush beats a simultaneous miss
    @(negedge clk); req_valid = 1'b1; inst_addr = 32'h6000; flush = 1'b1; #1;
    chk("prio_ready", ready, 0);
    @(negedge clk); flush = 1'b0; req_valid = 1'b0; #1;
    chk("prio_no_ar", m_arvalid, 0);
    chk("prio_busy", busy, 1);
    m_clear();
    wait_idle(n);
    chk("prio_flush_len", n, SETS);

    // flush during R is deferred until the refill completes
    fetch_ok(32'h2000);
    fetch(32'h2040, -1, LW - 1, 3, -1, 0, 0);
    fetch_ok(32'h2040);

    // randomized traffic over a small pool of lines
    mode = 1'b1;
    do_reset();
    set_base($urandom & 32'hFFFF_FFFC);
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0) begin
        set_base($urandom & 32'hFFFF_FFFC);
      end else if (r == 1) begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        m_clear();
        wait_idle(n);
        chk("rnd_flush_len", n, SETS);
      end else if (r == 2) begin
        @(negedge clk); m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = $urandom;
        @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        chk("stray_idle", busy, 0);
      end else begin
        pa = (32'($urandom_range(0, 3)) << (OFF + IDXB))
           | (32'($urandom_range(0, 2) * 97 + 3) << OFF)
           | (32'($urandom_range(0, LW - 1)) << 2);
        fetch(pa - base_m, -1, LW - 1, -1, -1, $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    // AXI error response on beat 5
    mode = 1'b0;
    do_reset();
    fetch(32'h3000, 5, LW - 1, -1, -1, 0, 0);
    // early rlast on beat 7
    do_reset();
    fetch(32'h3000, -1, 7, -1, -1, 0, 0);

    // reset during beat 8 aborts the refill and invalidates everything
    do_reset();
    fetch(32'h4000, -1, LW - 1, -1, 8, 1, 0);
    fetch_ok(32'h4000);
    fetch_ok(32'h4004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
